// File: rtl/link_enable_sequencer.sv
// Host link supervisor: frame qualification, link watchdog, link state machine
// and staggered gating of the per-axis enables.
module link_enable_sequencer #(
    parameter int unsigned BUFFER_SIZE = 168,
    parameter logic [31:0] HEADER      = 32'h74697277,
    parameter int unsigned TIMEOUT     = 3000000,
    parameter int unsigned ARM_FRAMES  = 3,
    parameter int unsigned AXES        = 3,
    parameter int unsigned STAGGER     = 30000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync,
    input  logic [BUFFER_SIZE-1:0] rx_data,
    input  logic [AXES-1:0]        axis_enable_req,
    output logic [BUFFER_SIZE-1:0] frame_data,
    output logic                   frame_strobe,
    output logic [AXES-1:0]        axis_enable,
    output logic                   error,
    output logic [1:0]             state,
    output logic [15:0]            frame_count,
    output logic [7:0]             bad_frames
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam int unsigned ST_W = (STAGGER == 0) ? 1 : $clog2(STAGGER + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_next;
    logic [2:0]        sync_sr;
    logic              sync_edge;
    logic              hdr_ok;
    logic              frame_valid;
    logic              frame_bad;
    logic              timeout;
    logic [WD_W-1:0]   watchdog;
    logic [7:0]        good_cnt;
    logic [7:0]        good_next;
    logic [ST_W-1:0]   stagger_cnt;
    logic [ST_W-1:0]   stagger_next;
    logic [AXES-1:0]   enable_next;
    logic [AXES-1:0]   pending;
    logic              picked;

    assign sync_edge   = (sync_sr[2:1] == 2'b01);
    assign hdr_ok      = (rx_data[BUFFER_SIZE-1 -: 32] == HEADER);
    assign frame_valid = sync_edge & hdr_ok;
    assign frame_bad   = sync_edge & ~hdr_ok;
    assign timeout     = (watchdog == WD_W'(TIMEOUT));
    assign state       = state_q;

    // Synchronise sync, latch accepted frames and keep the frame counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr      <= '0;
            frame_data   <= '0;
            frame_strobe <= 1'b0;
            frame_count  <= '0;
            bad_frames   <= '0;
        end else begin
            sync_sr      <= {sync_sr[1:0], sync};
            frame_strobe <= frame_valid;
            if (frame_valid) begin
                frame_data  <= rx_data;
                frame_count <= frame_count + 16'd1;
            end
            if (frame_bad && (bad_frames != 8'hFF)) begin
                bad_frames <= bad_frames + 8'd1;
            end
        end
    end

    // Link watchdog: cleared by a valid frame, otherwise counts up to TIMEOUT and holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            watchdog <= '0;
        end else if (frame_valid) begin
            watchdog <= '0;
        end else if (!timeout) begin
            watchdog <= watchdog + WD_W'(1);
        end
    end

    // State register; error is registered alongside so it tracks the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            good_cnt <= '0;
            error    <= 1'b1;
        end else begin
            state_q  <= state_next;
            good_cnt <= good_next;
            error    <= (state_next != ST_RUN);
        end
    end

    // Next-state logic; a valid frame outranks a coincident timeout.
    always_comb begin
        state_next = state_q;
        good_next  = good_cnt;
        if (frame_bad) begin
            good_next = '0;
        end
        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (frame_valid) begin
                    good_next  = 8'd1;
                    state_next = (ARM_FRAMES == 1) ? ST_RUN : ST_ARM;
                end
            end
            ST_ARM: begin
                if (frame_valid) begin
                    good_next = good_cnt + 8'd1;
                    if ((good_cnt + 8'd1) >= 8'(ARM_FRAMES)) begin
                        state_next = ST_RUN;
                    end
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_RUN: begin
                if (timeout && !frame_valid) begin
                    state_next = ST_FAULT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Enable gating: drop everything when leaving RUN, clear released bits at once,
    // raise requested bits one at a time. The counter is treated as expired on the
    // edge where it reaches zero, so rises land exactly STAGGER clocks apart.
    always_comb begin
        enable_next  = axis_enable;
        stagger_next = stagger_cnt;
        pending      = '0;
        picked       = 1'b0;
        if (stagger_cnt != '0) begin
            stagger_next = stagger_cnt - ST_W'(1);
        end
        if (state_next != ST_RUN) begin
            enable_next = '0;
        end else if (state_q == ST_RUN) begin
            enable_next = axis_enable & axis_enable_req;
            pending     = axis_enable_req & ~enable_next;
            if (STAGGER == 0) begin
                enable_next = axis_enable_req;
            end else if ((stagger_cnt <= ST_W'(1)) && (pending != '0)) begin
                for (int unsigned i = 0; i < AXES; i++) begin
                    if (!picked && pending[i]) begin
                        enable_next[i] = 1'b1;
                        picked         = 1'b1;
                    end
                end
                stagger_next = ST_W'(STAGGER);
            end
        end
    end

    // Enable and stagger counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_enable <= '0;
            stagger_cnt <= '0;
        end else begin
            axis_enable <= enable_next;
            stagger_cnt <= stagger_next;
        end
    end

endmodule
